// File: rtl/nibble_serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// nibble_serial_subtractor_pkg
//
// Purpose : Shared definitions for the nibble-serial subtractor: FSM state
//           encoding, slice width and helpers that derive the slice count and
//           the slice-index register width from the operand width.
// Contents: state_t     - FSM states IDLE / BUSY / DONE
//           SLICE_W     - bits processed per clock (4)
//           nslice_of() - number of slices for a given operand width
//           idx_width() - bits needed for the slice index, minimum 1
// -----------------------------------------------------------------------------
package nibble_serial_subtractor_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int SLICE_W = 4;

   // Operand width must be a non-zero multiple of SLICE_W.
   function automatic int nslice_of(input int width);
      return width / SLICE_W;
   endfunction

   // A single-slice configuration still needs a one-bit index register so the
   // index port widths never collapse to zero.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : nibble_serial_subtractor_pkg

// File: rtl/nibble_serial_subtractor_if.sv
// -----------------------------------------------------------------------------
// nibble_serial_subtractor_if
//
// Purpose : Request/result bundle for the nibble-serial subtractor.
// Signals : start - request, sampled only while the subtractor is IDLE or DONE
//           a     - minuend, captured when start is accepted
//           b     - subtrahend, captured when start is accepted
//           bin   - borrow-in, captured when start is accepted
//           busy  - high while slices are being processed
//           done  - one-cycle pulse when diff/bout/ovf become valid
//           diff  - a - b - bin modulo 2^WIDTH
//           bout  - final borrow-out (unsigned a < b + bin)
//           ovf   - signed overflow of the subtraction
// Modports: master - the requester (drives start/a/b/bin)
//           slave  - the subtractor (drives busy/done/diff/bout/ovf)
// -----------------------------------------------------------------------------
interface nibble_serial_subtractor_if #(
   parameter int WIDTH = 16
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             ovf;

   modport master (
      output start, a, b, bin,
      input  busy, done, diff, bout, ovf
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, diff, bout, ovf
   );

endinterface : nibble_serial_subtractor_if

// File: rtl/nibble_serial_subtractor_bla4.sv
// -----------------------------------------------------------------------------
// borrow_lookahead_4
//
// Purpose : Purely combinational 4-bit borrow-lookahead subtractor slice,
//           d = a - b - bin over four bits.
// Ports   : a_i[3:0] - minuend slice
//           b_i[3:0] - subtrahend slice
//           bin_i    - borrow into bit 0
//           d_o[3:0] - difference slice
//           bout_o   - borrow out of bit 3
//
// Borrow generate g = ~a & b (a 0-1 always borrows) and propagate
// p = ~(a ^ b) (equal bits pass an incoming borrow through). Every internal
// borrow is expanded as a sum of products straight from g/p/bin, so no borrow
// depends on a previous stage's borrow output.
// -----------------------------------------------------------------------------
module borrow_lookahead_4
   import nibble_serial_subtractor_pkg::*;
(
   input  logic [SLICE_W-1:0] a_i,
   input  logic [SLICE_W-1:0] b_i,
   input  logic               bin_i,
   output logic [SLICE_W-1:0] d_o,
   output logic               bout_o
);

   logic [SLICE_W-1:0] g;
   logic [SLICE_W-1:0] p;
   logic [SLICE_W:0]   br;

   generate
      for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_gp
         assign g[gi] = ~a_i[gi] & b_i[gi];
         assign p[gi] = ~(a_i[gi] ^ b_i[gi]);
      end
   endgenerate

   // Flattened lookahead terms.
   assign br[0] = bin_i;
   assign br[1] = g[0]
                | (p[0] & bin_i);
   assign br[2] = g[1]
                | (p[1] & g[0])
                | (p[1] & p[0] & bin_i);
   assign br[3] = g[2]
                | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & bin_i);
   assign br[4] = g[3]
                | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & bin_i);

   generate
      for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_diff
         assign d_o[gi] = a_i[gi] ^ b_i[gi] ^ br[gi];
      end
   endgenerate

   assign bout_o = br[SLICE_W];

endmodule : borrow_lookahead_4

// File: rtl/nibble_serial_subtractor.sv
// -----------------------------------------------------------------------------
// nibble_serial_subtractor
//
// Purpose : Sequential subtractor computing diff = a - b - bin over WIDTH bits,
//           one 4-bit slice per clock, least significant slice first. A single
//           borrow_lookahead_4 is shared by all slices through an index mux;
//           the slice borrow-out is registered and becomes the next slice's
//           borrow-in.
// Params  : WIDTH - operand/result width, a non-zero multiple of 4.
// Ports   : clk  - rising-edge clock
//           rst  - asynchronous, active-high reset
//           bus  - nibble_serial_subtractor_if.slave (start/a/b/bin in,
//                  busy/done/diff/bout/ovf out, all outputs registered)
// Timing  : done pulses in the cycle after the NSLICE-th rising edge following
//           the accepting edge; a new start is accepted in IDLE or DONE, so
//           back-to-back throughput is one operation per NSLICE+1 cycles.
// -----------------------------------------------------------------------------
module nibble_serial_subtractor
   import nibble_serial_subtractor_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   nibble_serial_subtractor_if.slave    bus
);

   localparam int NSLICE = nslice_of(WIDTH);
   localparam int IDX_W  = idx_width(NSLICE);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_t           state_q;
   logic [IDX_W-1:0] idx_q;
   logic             borrow_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] diff_q;
   logic             bout_q;
   logic             ovf_q;
   logic             busy_q;
   logic             done_q;

   // ---------------------------------------------------------------------
   // Slice datapath
   // ---------------------------------------------------------------------
   // Bit offset of the active slice: idx * 4, formed by appending two zeros.
   logic [IDX_W+1:0]   base;
   logic [SLICE_W-1:0] a_slice;
   logic [SLICE_W-1:0] b_slice;
   logic [SLICE_W-1:0] d_slice;
   logic               br_out;
   logic               ovf_d;

   assign base    = {idx_q, 2'b00};
   assign a_slice = a_q[base +: SLICE_W];
   assign b_slice = b_q[base +: SLICE_W];

   borrow_lookahead_4 u_bla (
      .a_i    (a_slice),
      .b_i    (b_slice),
      .bin_i  (borrow_q),
      .d_o    (d_slice),
      .bout_o (br_out)
   );

   // Overflow is evaluated on the last slice, whose top bit is the final
   // result MSB: operands of differing sign overflow when the result sign
   // differs from the minuend sign.
   assign ovf_d = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ d_slice[SLICE_W-1]);

   // ---------------------------------------------------------------------
   // Control FSM with registered outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         borrow_q <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         diff_q   <= '0;
         bout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            // DONE behaves like IDLE for acceptance; done only lasts one cycle.
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  a_q      <= bus.a;
                  b_q      <= bus.b;
                  borrow_q <= bus.bin;
                  idx_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= BUSY;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end

            BUSY: begin
               diff_q[base +: SLICE_W] <= d_slice;
               borrow_q                <= br_out;
               if (idx_q == LAST_IDX) begin
                  bout_q  <= br_out;
                  ovf_q   <= ovf_d;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end

            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.diff = diff_q;
   assign bus.bout = bout_q;
   assign bus.ovf  = ovf_q;

endmodule : nibble_serial_subtractor

// File: doc/nibble_serial_subtractor.md
Name: nibble_serial_subtractor

Overview:
- Sequential unsigned/two's-complement subtractor computing diff = a - b - bin over WIDTH bits, one 4-bit slice per clock, LSB slice first.
- Each slice uses 4-bit borrow-lookahead logic; the slice borrow-out is registered and feeds the next slice's borrow-in.
- Sits next to the team's carry-lookahead adder datapath as its subtract-side counterpart. It trades latency for area on wide operands.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4. NSLICE = WIDTH/4.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  minuend; captured when start is accepted.
- b  input  WIDTH  subtrahend; captured when start is accepted.
- bin  input  1  borrow-in; captured when start is accepted.
- busy  output  1  high while slices are being processed.
- done  output  1  one-cycle pulse when results become valid.
- diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
- bout  output  1  final borrow-out; 1 iff a < b + bin, unsigned.
- ovf  output  1  signed overflow flag.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset values: state=IDLE, slice index=0, internal borrow=0, busy=0, done=0, diff=0, bout=0, ovf=0.
- Reset mid-operation: same as above, immediately. The partial result is discarded and no done pulse is issued.
- FSM state IDLE: busy=0, done=0. On start=1, latch a, b and bin, set index=0 and borrow=bin, then go to BUSY.
- FSM state BUSY: busy=1. On each edge, compute slice [4*idx+3 : 4*idx] and write it into the diff register.
  - Borrow-lookahead equations for bit i of the slice:
    - g_i = ~a_i & b_i
    - p_i = ~(a_i ^ b_i)
    - br_{i+1} = g_i | (p_i & br_i)
    - d_i = a_i ^ b_i ^ br_i
  - br_0 is the registered borrow; br_4 becomes the new registered borrow.
  - When idx = NSLICE-1, set bout = br_4 and ovf = (a_msb ^ b_msb) & (a_msb ^ diff_msb) using the final diff, then go to DONE. Otherwise increment idx.
- FSM state DONE: done=1 for exactly this cycle, busy=0.
  - With start=1: accept a new operation, same as IDLE, and go to BUSY.
  - Otherwise go to IDLE.
- Latency: done=1 in the cycle following the NSLICE-th rising edge after the accepting edge (4 edges for WIDTH=16). Throughput is one operation per NSLICE+1 cycles.
- Output hold: diff, bout and ovf are updated only during BUSY. Between done and the next accepted start they hold their value.
  - Slice writes during a new operation make diff transiently mixed. Results are valid only from done onward.
- start while BUSY: ignored, with no queueing.
- Input changes on a, b or bin after acceptance: no effect on the result.
- Wrap-around: the result is modulo 2^WIDTH. The borrow out of the top slice is reported on bout only.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package holds:
  - FSM state enum {IDLE, BUSY, DONE}
  - SLICE_W = 4
  - NSLICE derivation
  - index width function clog2(NSLICE), minimum 1
- Sub-module borrow_lookahead_4: purely combinational. Inputs a[3:0], b[3:0], bin. Outputs d[3:0], bout. Implements the g/p equations above in flattened lookahead form, not rippled. It is instantiated once and muxed by the slice index.

Test Plan (WIDTH=16):
- a=0x1234, b=0x0034, bin=0, start pulse -> done 4 cycles later; diff=0x1200, bout=0, ovf=0; busy high for exactly 4 cycles.
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0. The borrow ripples through all four slices.
- a=0x8000, b=0x0001 -> diff=0x7FFF, bout=0, ovf=1. Then a=0x7FFF, b=0xFFFF -> diff=0x8000, bout=1, ovf=1.
- a=0x0005, b=0x0003, bin=1 -> diff=0x0001, bout=0. Then a=0x0000, b=0x0000, bin=1 -> diff=0xFFFF, bout=1.
- Start a=0x00F0, b=0x0001. Re-pulse start with a=0xFFFF, b=0 during BUSY -> ignored; diff=0x00EF.
  - In the DONE cycle pulse start with a=0x0010, b=0x0010 -> back-to-back accept; next done gives diff=0x0000.
- Assert rst for 1 cycle midway (after 2 slices) -> all outputs 0 immediately and no done pulse. A new start then completes normally.
